// File: rtl/sm_calc_pkg.sv
// Shared types and helpers for the sequential sign-magnitude calculator units.
package sm_calc_pkg;

  typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} state_t;

  function automatic int nchunks(input int mag_w, input int chunk);
    return (mag_w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/sm_addsub_seq_if.sv
// Level-sensitive start/finish handshake and operand/result bus of the add/sub unit.
interface sm_addsub_seq_if #(parameter int WIDTH = 16);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] out;
  logic             ovf;
  logic             busy;
  logic             finish;

  modport master (output start, sub, in_a, in_b, input out, ovf, busy, finish);
  modport slave  (input start, sub, in_a, in_b, output out, ovf, busy, finish);

endinterface

// File: rtl/sm_chunk_adder.sv
// W-bit ripple adder; each B bit is XORed with its own invert bit before the add.
module sm_chunk_adder #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] bx;

  always_comb begin
    c    = '0;
    sum  = '0;
    bx   = b ^ inv;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[W];

endmodule

// File: rtl/sm_addsub_seq.sv
// Sequential sign-magnitude add/sub: magnitudes combined CHUNK bits per cycle,
// with an optional second pass that two's-complements the magnitude when |B| > |A|.
module sm_addsub_seq
  import sm_calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 5
) (
  input  logic            clk,
  input  logic            nRST,
  sm_addsub_seq_if.slave  bus
);

  localparam int MAG_W     = WIDTH - 1;
  localparam int NCH       = nchunks(MAG_W, CHUNK);
  localparam int PAD_W     = NCH * CHUNK;
  localparam int LAST_BITS = MAG_W - (NCH - 1) * CHUNK;
  localparam int IDX_W     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [PAD_W:0]   MASK_EXT = ((PAD_W+1)'(1) << MAG_W) - (PAD_W+1)'(1);
  localparam logic [PAD_W-1:0] MAG_MASK = MASK_EXT[PAD_W-1:0];

  state_t             state, state_nxt;
  logic [PAD_W-1:0]   a_mag, b_mag, acc, acc_nxt;
  logic [IDX_W-1:0]   idx;
  logic               carry, carry_nxt, es, a_sign;
  logic [WIDTH-1:0]   out_q;
  logic               ovf_q, finish_q;

  logic               ld, step, to_neg, wr_res, leave_done, last;
  int                 base;
  logic [CHUNK-1:0]   op_a, op_b, op_inv, sum;
  logic               cout, top_carry;
  logic [MAG_W-1:0]   res_mag;
  logic               res_sign, res_ovf;

  assign last = (idx == IDX_W'(NCH - 1));
  assign base = int'(idx) * CHUNK;

  // ADD feeds A and (optionally inverted) B; NEG feeds 0 and inverted acc.
  // Inversion is masked to real magnitude bits so padding stays zero.
  always_comb begin
    op_a   = '0;
    op_b   = acc[base +: CHUNK];
    op_inv = MAG_MASK[base +: CHUNK];
    if (state == ADD) begin
      op_a   = a_mag[base +: CHUNK];
      op_b   = b_mag[base +: CHUNK];
      op_inv = es ? MAG_MASK[base +: CHUNK] : '0;
    end
  end

  sm_chunk_adder #(.W(CHUNK)) u_chunk (
    .a    (op_a),
    .b    (op_b),
    .inv  (op_inv),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // Carry out of the magnitude lands in the first padding bit when the last chunk is partial.
  if (LAST_BITS == CHUNK) begin : g_full_last
    assign top_carry = cout;
  end else begin : g_pad_last
    assign top_carry = sum[LAST_BITS];
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ld         = 1'b0;
    step       = 1'b0;
    to_neg     = 1'b0;
    wr_res     = 1'b0;
    leave_done = 1'b0;
    carry_nxt  = last ? top_carry : cout;
    acc_nxt    = acc;
    acc_nxt[base +: CHUNK] = sum;
    case (state)
      IDLE: begin
        if (bus.start) begin
          ld        = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        step = 1'b1;
        if (last) begin
          if (es && !carry_nxt) begin
            to_neg    = 1'b1;
            state_nxt = NEG;
          end else begin
            wr_res    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      NEG: begin
        step = 1'b1;
        if (last) begin
          wr_res    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.start) begin
          leave_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign res_mag  = acc_nxt[MAG_W-1:0];
  assign res_sign = ((state == NEG) ? ~a_sign : a_sign) & (|res_mag);
  assign res_ovf  = (state == ADD) & ~es & carry_nxt;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      es       <= 1'b0;
      a_sign   <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      if (ld) begin
        a_mag  <= PAD_W'(bus.in_a[MAG_W-1:0]);
        b_mag  <= PAD_W'(bus.in_b[MAG_W-1:0]);
        a_sign <= bus.in_a[MAG_W];
        es     <= bus.in_a[MAG_W] ^ bus.in_b[MAG_W] ^ bus.sub;
        carry  <= bus.in_a[MAG_W] ^ bus.in_b[MAG_W] ^ bus.sub;
        acc    <= '0;
        idx    <= '0;
      end else if (step) begin
        acc <= acc_nxt;
        if (last) begin
          idx   <= '0;
          carry <= to_neg ? 1'b1 : carry_nxt;
        end else begin
          idx   <= idx + 1'b1;
          carry <= carry_nxt;
        end
      end
      if (wr_res) begin
        out_q    <= {res_sign, res_mag};
        ovf_q    <= res_ovf;
        finish_q <= 1'b1;
      end
      if (leave_done) finish_q <= 1'b0;
    end
  end

  assign bus.out    = out_q;
  assign bus.ovf    = ovf_q;
  assign bus.finish = finish_q;
  assign bus.busy   = (state == ADD) || (state == NEG);

endmodule

// File: doc/sm_addsub_seq.md
Name: sm_addsub_seq

Overview:
- Parametrised sign-magnitude adder/subtractor for the calculator datapath.
- Operand format: MSB is the sign; the low WIDTH-1 bits are the magnitude.
- Generalises the fixed 16-bit add/sub unit in three ways:
  - configurable WIDTH;
  - a chunked, multi-cycle magnitude datapath (CHUNK bits per cycle) to trade area against latency;
  - new outputs: overflow flag, busy indication and negative-zero normalisation.
- Uses the same level-sensitive start/finish handshake as the existing arithmetic units.

Parameters:
- WIDTH, 16: total operand/result width including the sign bit; must be at least 3.
- CHUNK, 5: magnitude bits processed per cycle; 1 <= CHUNK <= WIDTH-1. Derived: MAG_W = WIDTH-1, NCH = ceil(MAG_W/CHUNK).

Ports:
- clk  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- start  in  1  level request; sampled only in IDLE
- sub  in  1  1 = in_a - in_b, 0 = in_a + in_b
- in_a  in  WIDTH  sign-magnitude operand A
- in_b  in  WIDTH  sign-magnitude operand B
- out  out  WIDTH  sign-magnitude result, registered
- ovf  out  1  magnitude overflow of the last result, registered
- busy  out  1  high in ADD or NEG
- finish  out  1  result valid; held until start deasserts

Behaviour:
- Reset: state=IDLE, out=0, ovf=0, finish=0, busy=0; all internal registers cleared. Reset mid-operation aborts the operation, with no partial result visible.
- States: IDLE, ADD, NEG, DONE.
- IDLE, on an edge with start=1:
  - Latch the operands.
  - Compute es = a_sign ^ b_sign ^ sub.
  - Set chunk index 0 and carry register = es.
  - Go to ADD.
- ADD, per edge: process chunk i of mag_a + (es ? ~mag_b : mag_b) + carry.
  - Write sum bits into the accumulator and store carry-out.
  - The final chunk is zero-padded above MAG_W; carry is taken from bit MAG_W.
  - After chunk NCH-1:
    - If es=1 and carry=0 (|B|>|A|): go to NEG, index 0, carry=1.
    - Otherwise: go to DONE and write the result.
- NEG: NCH edges computing acc = ~acc + carry chunk-wise (two's complement of the magnitude), then DONE with result write.
- Result write happens on the edge entering DONE; finish=1 on that same edge.
  - es=0: sign = a_sign; ovf = final carry; magnitude wraps modulo 2^MAG_W.
  - es=1, no NEG: sign = a_sign; ovf=0.
  - es=1, via NEG: sign = ~a_sign; ovf=0.
  - If the result magnitude is 0, sign is forced to 0 (no -0 output), including the overflow-wrap case.
- Latency, from the edge that samples start in IDLE: finish rises NCH edges later without NEG, 2*NCH edges later with NEG. Defaults (NCH=3): 3 or 6.
- DONE: out, ovf and finish are held. On an edge with start=0, go to IDLE and clear finish; out and ovf hold until the next result write.
- start held high through DONE never retriggers; a new operation requires start low for at least one edge.
- start dropping during ADD/NEG is ignored; the operation completes, then DONE exits on the next edge.
- in_a, in_b and sub changes after latching are ignored.
- Input -0 (sign=1, magnitude=0) is accepted and treated as zero magnitude.

Decomposition:
- Package sm_calc_pkg:
  - state_t enum {IDLE, ADD, NEG, DONE};
  - constant function nchunks(mag_w, chunk).
  - To be shared with future multiply/divide units.
- Sub-module sm_chunk_adder: CHUNK-bit ripple adder with per-bit B-invert and carry-in/carry-out. One instance serves both ADD (A, B^es) and NEG (0, acc inverted), with the operand mux in the parent.

Test Plan:
- WIDTH=16/CHUNK=5: in_a=0x0005, in_b=0x0003, sub=0 -> out=0x0008, ovf=0, finish 3 edges after start sampled.
- in_a=0x0005, in_b=0x0009, sub=1 -> NEG path; out=0x8004, ovf=0, finish at edge +6, busy high for 6 cycles.
- in_a=0x8007, in_b=0x0007, sub=0 -> out=0x0000 (sign normalised), ovf=0.
- in_a=0xFFFF, in_b=0x8002, sub=0 -> out=0x8001, ovf=1. Then in_a=0x7FFF, in_b=0x0001 -> out=0x0000, ovf=1.
- Handshake and reset:
  - Hold start high 5 cycles after finish -> no retrigger, out stable.
  - Drop start -> finish=0 next edge.
  - Toggle in_a mid-ADD -> result unchanged.
  - Assert nRST mid-NEG -> out=0, finish=0, busy=0 immediately.
- Parameter sweep, WIDTH=8 with CHUNK in {1,3,7}: 0x05 - 0x09 -> 0x84 with latency 2*NCH (14, 6, 2). Randomised sign-magnitude compare vs reference model for 1000 ops.
